// File: rtl/conv5x5_engine_pkg.sv
// Shared constants, FSM state encoding and kernel indexing for the 5x5 convolution engine.
// Tap index convention: wrow 0 is the top (oldest) row, wcol 0 is the leftmost (oldest) column.
package conv_pkg;

    localparam int CONV_IMG_W  = 28;
    localparam int CONV_IMG_H  = 28;
    localparam int CONV_K      = 5;
    localparam int CONV_DATA_W = 8;
    localparam int CONV_COEF_W = 8;
    localparam int CONV_ACC_W  = 24;

    localparam int CONV_OUT_COUNT = (CONV_IMG_W - CONV_K + 1) * (CONV_IMG_H - CONV_K + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

    function automatic int coef_idx(input int wrow, input int wcol);
        return wrow * CONV_K + wcol;
    endfunction

endpackage

// File: rtl/conv5x5_engine_mac25.sv
// Two-stage multiply/accumulate for a 25-tap window: registered products, then registered sum.
// Build option CONV_RELU_EN clamps negative sums to zero in the output stage.
module conv_mac25
    import conv_pkg::*;
#(
    parameter int K      = CONV_K,
    parameter int DATA_W = CONV_DATA_W,
    parameter int COEF_W = CONV_COEF_W,
    parameter int ACC_W  = CONV_ACC_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    input  logic [K*K*DATA_W-1:0]     win,
    input  logic [K*K*COEF_W-1:0]     coef,
    output logic [ACC_W-1:0]          dout,
    output logic                      dout_valid
);

    localparam int NTAP   = K * K;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(NTAP);

    logic signed [PROD_W-1:0] prod_r [NTAP];
    logic                     prod_valid_r;
    logic signed [SUM_W-1:0]  sum_s;
    logic signed [SUM_W-1:0]  res_s;
    logic [ACC_W-1:0]         dout_r;
    logic                     dout_valid_r;

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;

    // Pixels are unsigned, so they are zero-extended before the signed multiply.
    function automatic logic signed [PROD_W-1:0] mul_px(input logic [DATA_W-1:0] px,
                                                         input logic [COEF_W-1:0] cf);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = $signed({{(PROD_W-DATA_W){1'b0}}, px});
        b = $signed({{(PROD_W-COEF_W){cf[COEF_W-1]}}, cf});
        return a * b;
    endfunction

    // Product stage: all 25 products registered every cycle, qualified by prod_valid_r.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NTAP; i++) begin
                prod_r[i] <= '0;
            end
            prod_valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < NTAP; i++) begin
                prod_r[i] <= mul_px(win[i*DATA_W +: DATA_W], coef[i*COEF_W +: COEF_W]);
            end
            prod_valid_r <= in_valid;
        end
    end

    // Adder tree and optional clamp.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NTAP; i++) begin
            sum_s = sum_s + {{(SUM_W-PROD_W){prod_r[i][PROD_W-1]}}, prod_r[i]};
        end
`ifdef CONV_RELU_EN
        if (sum_s[SUM_W-1]) begin
            res_s = '0;
        end else begin
            res_s = sum_s;
        end
`else
        res_s = sum_s;
`endif
    end

    // Output stage: dout only updates on a valid result and holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            if (prod_valid_r) begin
                dout_r <= {{(ACC_W-SUM_W){res_s[SUM_W-1]}}, res_s};
            end else begin
                dout_r <= dout_r;
            end
            dout_valid_r <= prod_valid_r;
        end
    end

endmodule

// File: rtl/conv5x5_engine.sv
// 5x5 convolution engine: frame FSM, raster counters, window register and coefficient file.
// Define CONV_RELU_EN to clamp negative results to zero (handled in conv_mac25).
module conv5x5_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = CONV_IMG_W,
    parameter int IMG_H  = CONV_IMG_H,
    parameter int K      = CONV_K,
    parameter int DATA_W = CONV_DATA_W,
    parameter int COEF_W = CONV_COEF_W,
    parameter int ACC_W  = CONV_ACC_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  din_valid,
    input  logic [K*DATA_W-1:0]   taps,
    input  logic                  coef_we,
    input  logic [4:0]            coef_addr,
    input  logic [COEF_W-1:0]     coef_data,
    output logic [ACC_W-1:0]      dout,
    output logic                  dout_valid,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int NTAP  = K * K;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(K - 1);

    conv_state_e             state_r;
    logic [COL_W-1:0]        col_r;
    logic [ROW_W-1:0]        row_r;
    logic [1:0]              drain_cnt_r;
    logic                    busy_r;
    logic                    frame_done_r;
    logic [NTAP*DATA_W-1:0]  win_r;
    logic                    win_valid_r;
    logic [NTAP*COEF_W-1:0]  coef_r;
    logic                    beat_s;
    logic                    win_done_s;
    logic                    coef_wr_s;

    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Beat qualification and coefficient write gating.
    always_comb begin
        beat_s     = (state_r == ST_RUN) && din_valid;
        win_done_s = beat_s && (row_r >= ROW_MIN) && (col_r >= COL_MIN);
        coef_wr_s  = (state_r == ST_IDLE) && coef_we && (coef_addr < 5'(NTAP));
    end

    // Frame FSM with raster counters; DRAIN covers the three pipeline stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            col_r        <= '0;
            row_r        <= '0;
            drain_cnt_r  <= 2'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        col_r   <= '0;
                        row_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (beat_s) begin
                        if (col_r == COL_LAST) begin
                            col_r <= '0;
                            if (row_r == ROW_LAST) begin
                                state_r     <= ST_DRAIN;
                                drain_cnt_r <= 2'd0;
                            end else begin
                                row_r <= row_r + ROW_W'(1);
                            end
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == 2'd2) begin
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Window shifts left by one column per beat; the new column enters at wcol K-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_r       <= '0;
            win_valid_r <= 1'b0;
        end else begin
            win_valid_r <= win_done_s;
            if (beat_s) begin
                for (int wr = 0; wr < K; wr++) begin
                    for (int wc = 0; wc < K - 1; wc++) begin
                        win_r[coef_idx(wr, wc)*DATA_W +: DATA_W] <=
                            win_r[coef_idx(wr, wc + 1)*DATA_W +: DATA_W];
                    end
                    win_r[coef_idx(wr, K - 1)*DATA_W +: DATA_W] <= taps[wr*DATA_W +: DATA_W];
                end
            end else begin
                win_r <= win_r;
            end
        end
    end

    // Coefficient file, writable only while idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coef_r <= '0;
        end else begin
            if (coef_wr_s) begin
                coef_r[coef_addr*COEF_W +: COEF_W] <= coef_data;
            end else begin
                coef_r <= coef_r;
            end
        end
    end

    conv_mac25 #(
        .K      (K),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (win_valid_r),
        .win        (win_r),
        .coef       (coef_r),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule
